fetch_sequencer: RTL and testbench

- Front end of the 8-bit core. Drives the PC register's write port (next-PC value and write-enable) and reads back its current value.
- Fetches opcode bytes from instruction memory over a req/ack handshake, plus an argument byte for two-byte instructions.
- Holds each complete instruction for decode behind a valid/ready handshake.
- Redirects fetch on branch requests from execute, discarding any in-flight or held instruction.

---
 rtl/fetch_sequencer_if.sv | 29 ++
 rtl/fetch_sequencer.sv | 118 +++++++++++
 tb/tb_fetch_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch front-end bus: PC register write/read, instruction memory, decode and branch ports.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] pc_cur;
  logic [ADDR_W-1:0] pc_next;
  logic              pc_we;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [7:0]        imem_rdata;
  logic              instr_valid;
  logic [7:0]        instr_op;
  logic [7:0]        instr_arg;
  logic              instr_long;
  logic              instr_ready;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;

  modport master (
    input  pc_cur, imem_ack, imem_rdata, instr_ready, branch_valid, branch_target,
    output pc_next, pc_we, imem_req, imem_addr, instr_valid, instr_op, instr_arg, instr_long
  );

  modport slave (
    output pc_cur, imem_ack, imem_rdata, instr_ready, branch_valid, branch_target,
    input  pc_next, pc_we, imem_req, imem_addr, instr_valid, instr_op, instr_arg, instr_long
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch front end: fetches one- or two-byte instructions, holds them for decode,
// and redirects on branches, discarding in-flight or held instructions.
module fetch_sequencer #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [7:0]  LONG_MASK  = 8'hF0,
  parameter logic [7:0]  LONG_MATCH = 8'hD0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {START, REQ_OP, REQ_ARG, DELIVER} state_e;

  state_e            state_q, state_d;
  logic              flush_pend_q, flush_pend_d;
  logic [ADDR_W-1:0] tgt_pend_q, tgt_pend_d;
  logic [7:0]        op_q, op_d;
  logic [7:0]        arg_q, arg_d;
  logic              long_q, long_d;

  logic              pc_we_c;
  logic [ADDR_W-1:0] pc_next_c;
  logic              in_req_c;
  logic              is_long_c;

  assign in_req_c  = (state_q == REQ_OP) || (state_q == REQ_ARG);
  assign is_long_c = (bus.imem_rdata & LONG_MASK) == LONG_MATCH;

  // Next-state, capture and PC-write decode
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    tgt_pend_d   = tgt_pend_q;
    op_d         = op_q;
    arg_d        = arg_q;
    long_d       = long_q;
    pc_we_c      = 1'b0;
    pc_next_c    = bus.pc_cur + ADDR_W'(1);

    case (state_q)
      START: begin
        state_d = REQ_OP;
        if (bus.branch_valid) begin
          pc_we_c   = 1'b1;
          pc_next_c = bus.branch_target;
        end
      end

      REQ_OP, REQ_ARG: begin
        if (bus.imem_ack) begin
          pc_we_c      = 1'b1;
          flush_pend_d = 1'b0;
          if (bus.branch_valid) begin
            pc_next_c = bus.branch_target;
            state_d   = REQ_OP;
          end else if (flush_pend_q) begin
            pc_next_c = tgt_pend_q;
            state_d   = REQ_OP;
          end else if (state_q == REQ_OP) begin
            op_d    = bus.imem_rdata;
            arg_d   = 8'h00;
            long_d  = 1'b0;
            state_d = is_long_c ? REQ_ARG : DELIVER;
          end else begin
            arg_d   = bus.imem_rdata;
            long_d  = 1'b1;
            state_d = DELIVER;
          end
        end else if (bus.branch_valid) begin
          // Request must complete at the old address; remember where to go afterwards
          flush_pend_d = 1'b1;
          tgt_pend_d   = bus.branch_target;
        end
      end

      DELIVER: begin
        if (bus.branch_valid) begin
          pc_we_c   = 1'b1;
          pc_next_c = bus.branch_target;
          state_d   = REQ_OP;
        end else if (bus.instr_ready) begin
          state_d = REQ_OP;
        end
      end

      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= START;
      flush_pend_q <= 1'b0;
      tgt_pend_q   <= '0;
      op_q         <= 8'h00;
      arg_q        <= 8'h00;
      long_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      tgt_pend_q   <= tgt_pend_d;
      op_q         <= op_d;
      arg_q        <= arg_d;
      long_q       <= long_d;
    end
  end

  assign bus.pc_we       = pc_we_c;
  assign bus.pc_next     = pc_next_c;
  assign bus.imem_req    = in_req_c;
  assign bus.imem_addr   = bus.pc_cur;
  assign bus.instr_valid = (state_q == DELIVER);
  assign bus.instr_op    = op_q;
  assign bus.instr_arg   = arg_q;
  assign bus.instr_long  = long_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: PC register, memory with per-address wait
// states, and an instruction-stream model checked every cycle.
module tb_fetch_sequencer;

  logic clk;
  logic reset;

  fetch_sequencer_if #(.ADDR_W(8)) bus ();

  fetch_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment: PC register, memory image, wait-state responder
  logic [7:0] pc_q;
  logic [7:0] mem [256];
  int         wait_tbl [256];
  int         wcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          pc_q <= 8'h00;
    else if (bus.pc_we)  pc_q <= bus.pc_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         wcnt <= 0;
    else if (!bus.imem_req || bus.imem_ack) wcnt <= 0;
    else                                wcnt <= wcnt + 1;
  end

  assign bus.pc_cur     = pc_q;
  assign bus.imem_ack   = bus.imem_req && (wcnt == wait_tbl[bus.imem_addr]);
  assign bus.imem_rdata = mem[bus.imem_addr];

  // Instruction-stream model: where fetch must read next and what decode must see
  int          m_phase;      // 0 idle after reset, 1 fetching, 2 holding
  logic [7:0]  m_pc;
  bit          m_have_op;
  logic [7:0]  m_op, m_arg;
  bit          m_long;
  bit          m_redir;
  logic [7:0]  m_tgt;
  logic [7:0]  m_nxt;
  logic [16:0] dlog [$];

  always @(negedge clk) begin
    if (!reset) begin
      m_phase = 0; m_pc = 8'h00; m_have_op = 0; m_redir = 0;
    end else begin
      case (m_phase)
        0: begin
          chk("m_start_req", 32'(bus.imem_req), 32'd0);
          chk("m_start_valid", 32'(bus.instr_valid), 32'd0);
          chk("m_start_we", 32'(bus.pc_we), 32'(bus.branch_valid));
          if (bus.branch_valid) begin
            chk("m_start_pcnext", 32'(bus.pc_next), 32'(bus.branch_target));
            m_pc = bus.branch_target;
          end
          m_have_op = 0;
          m_phase = 1;
        end
        1: begin
          chk("m_fetch_req", 32'(bus.imem_req), 32'd1);
          chk("m_fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
          chk("m_fetch_valid", 32'(bus.instr_valid), 32'd0);
          if (bus.imem_ack) begin
            m_nxt = bus.branch_valid ? bus.branch_target : (m_redir ? m_tgt : 8'(m_pc + 8'd1));
            chk("m_ack_we", 32'(bus.pc_we), 32'd1);
            chk("m_ack_pcnext", 32'(bus.pc_next), 32'(m_nxt));
            if (bus.branch_valid || m_redir) begin
              m_redir = 0; m_have_op = 0;
            end else if (!m_have_op) begin
              m_op = bus.imem_rdata;
              if ((bus.imem_rdata & 8'hF0) == 8'hD0) m_have_op = 1;
              else begin m_arg = 8'h00; m_long = 0; m_phase = 2; end
            end else begin
              m_arg = bus.imem_rdata; m_long = 1; m_have_op = 0; m_phase = 2;
            end
            m_pc = m_nxt;
          end else begin
            chk("m_wait_we", 32'(bus.pc_we), 32'd0);
            if (bus.branch_valid) begin m_redir = 1; m_tgt = bus.branch_target; end
          end
        end
        default: begin
          chk("m_hold_valid", 32'(bus.instr_valid), 32'd1);
          chk("m_hold_op", 32'(bus.instr_op), 32'(m_op));
          chk("m_hold_arg", 32'(bus.instr_arg), 32'(m_arg));
          chk("m_hold_long", 32'(bus.instr_long), 32'(m_long));
          chk("m_hold_req", 32'(bus.imem_req), 32'd0);
          chk("m_hold_we", 32'(bus.pc_we), 32'(bus.branch_valid));
          if (bus.branch_valid) begin
            chk("m_hold_pcnext", 32'(bus.pc_next), 32'(bus.branch_target));
            m_pc = bus.branch_target; m_phase = 1;
          end else if (bus.instr_ready) begin
            dlog.push_back({m_op, m_arg, m_long});
            m_phase = 1;
          end
        end
      endcase
    end
  end

  task automatic wait_req(input logic [7:0] a);
    int n = 0;
    @(negedge clk);
    while (!(bus.imem_req === 1'b1 && bus.imem_addr === a) && n < 60) begin
      n++; @(negedge clk);
    end
    chk($sformatf("wait_req_%02h", a), 32'(n < 60), 32'd1);
  endtask

  task automatic wait_valid(input logic [7:0] op);
    int n = 0;
    @(negedge clk);
    while (!(bus.instr_valid === 1'b1 && bus.instr_op === op) && n < 60) begin
      n++; @(negedge clk);
    end
    chk($sformatf("wait_valid_%02h", op), 32'(n < 60), 32'd1);
  endtask

  logic [16:0] exp_log [10];

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; wait_tbl[i] = 0; end
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h20; mem[8'h02] = 8'h21; mem[8'h03] = 8'h22;
    mem[8'h04] = 8'hD3; mem[8'h05] = 8'h40; mem[8'h06] = 8'h30; mem[8'h07] = 8'hD5;
    mem[8'h08] = 8'h77; mem[8'h80] = 8'h41; mem[8'hFF] = 8'h01;
    wait_tbl[8'h01] = 1; wait_tbl[8'h04] = 2; wait_tbl[8'h05] = 2; wait_tbl[8'h08] = 4;
    exp_log = '{{8'h12, 8'h00, 1'b0}, {8'h20, 8'h00, 1'b0}, {8'h21, 8'h00, 1'b0},
                {8'h22, 8'h00, 1'b0}, {8'hD3, 8'h40, 1'b1}, {8'h30, 8'h00, 1'b0},
                {8'h01, 8'h00, 1'b0}, {8'h12, 8'h00, 1'b0}, {8'h12, 8'h00, 1'b0},
                {8'h20, 8'h00, 1'b0}};

    reset = 1'b0;
    bus.instr_ready = 1'b1;
    bus.branch_valid = 1'b0;
    bus.branch_target = 8'h00;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_op", 32'(bus.instr_op), 32'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // First fetch, zero-wait one-byte opcode
    @(negedge clk); chk("t1_start_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    chk("t1_addr", 32'(bus.imem_addr), 32'h00);
    chk("t1_we", 32'(bus.pc_we), 32'd1);
    chk("t1_pcnext", 32'(bus.pc_next), 32'h01);
    @(negedge clk);
    chk("t1_valid", 32'(bus.instr_valid), 32'd1);
    chk("t1_op", 32'(bus.instr_op), 32'h12);
    chk("t1_arg", 32'(bus.instr_arg), 32'h00);
    chk("t1_long", 32'(bus.instr_long), 32'd0);

    // Two-byte instruction with two wait states per byte
    @(posedge clk); #1;
    wait_req(8'h04);
    chk("t2_wait_we", 32'(bus.pc_we), 32'd0);
    repeat (2) @(negedge clk);
    chk("t2_ack_addr", 32'(bus.imem_addr), 32'h04);
    chk("t2_pcnext_op", 32'(bus.pc_next), 32'h05);
    @(negedge clk); chk("t2_arg_addr", 32'(bus.imem_addr), 32'h05);
    repeat (2) @(negedge clk);
    chk("t2_pcnext_arg", 32'(bus.pc_next), 32'h06);
    @(negedge clk);
    chk("t2_op", 32'(bus.instr_op), 32'hD3);
    chk("t2_arg", 32'(bus.instr_arg), 32'h40);
    chk("t2_long", 32'(bus.instr_long), 32'd1);
    @(posedge clk); #1 bus.instr_ready = 1'b0;

    // Decode stalls for five cycles
    wait_valid(8'h30);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3_op", 32'(bus.instr_op), 32'h30);
      chk("t3_req", 32'(bus.imem_req), 32'd0);
      chk("t3_we", 32'(bus.pc_we), 32'd0);
    end
    @(posedge clk); #1 bus.instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t3_next_req", 32'(bus.imem_req), 32'd1);
    chk("t3_next_addr", 32'(bus.imem_addr), 32'h07);

    // Two branches during the argument wait; the last one wins
    @(posedge clk); #1;
    wait_req(8'h08);
    @(posedge clk); #1 bus.branch_valid = 1'b1; bus.branch_target = 8'hF0;
    @(posedge clk); #1 bus.branch_target = 8'h80;
    @(posedge clk); #1 bus.branch_valid = 1'b0;
    @(negedge clk); chk("t4_addr_hold", 32'(bus.imem_addr), 32'h08);
    @(negedge clk);
    chk("t4_ack_addr", 32'(bus.imem_addr), 32'h08);
    chk("t4_pcnext", 32'(bus.pc_next), 32'h80);
    chk("t4_no_valid", 32'(bus.instr_valid), 32'd0);
    @(posedge clk); #1 bus.instr_ready = 1'b0;
    @(negedge clk); chk("t4_new_addr", 32'(bus.imem_addr), 32'h80);

    // Branch while holding beats a simultaneous ready; then wrap at FF
    @(posedge clk); #1;
    wait_valid(8'h41);
    @(posedge clk); #1 bus.branch_valid = 1'b1; bus.branch_target = 8'hFF; bus.instr_ready = 1'b1;
    @(negedge clk); chk("t5_we", 32'(bus.pc_we), 32'd1); chk("t5_pcnext", 32'(bus.pc_next), 32'hFF);
    @(posedge clk); #1 bus.branch_valid = 1'b0;
    wait_req(8'hFF);
    chk("t5_wrap", 32'(bus.pc_next), 32'h00);

    // Branch coinciding with ack uses the live target
    @(posedge clk); #1;
    wait_req(8'h01);
    @(posedge clk); #1 bus.branch_valid = 1'b1; bus.branch_target = 8'h04;
    @(negedge clk); chk("t6_pcnext", 32'(bus.pc_next), 32'h04);
    @(posedge clk); #1 bus.branch_valid = 1'b0;

    // Asynchronous reset in the middle of an opcode request
    @(negedge clk); chk("t7_req_before", 32'(bus.imem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t7_req", 32'(bus.imem_req), 32'd0);
    chk("t7_valid", 32'(bus.instr_valid), 32'd0);
    chk("t7_we", 32'(bus.pc_we), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); chk("t7_start_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk); chk("t7_addr", 32'(bus.imem_addr), 32'h00);
    wait_valid(8'h20);
    @(negedge clk);

    chk("log_len", 32'(dlog.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < dlog.size()) chk($sformatf("log_%0d", i), 32'(dlog[i]), 32'(exp_log[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule
